fp_adder_host_if: RTL and testbench

//  Host-side initiator for the FP_Adder bit-serial interface. Takes four parallel

---
 rtl/fp_adder_host_if_pkg.sv | 18 +
 rtl/fp_adder_host_if_if.sv | 42 ++++
 rtl/fp_serial_shift.sv | 41 ++++
 rtl/fp_adder_host_if.sv | 201 ++++++++++++++++++++
 tb/tb_fp_adder_host_if.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_adder_host_if_pkg.sv
// fp_adder_host_if shared definitions.
// Defaults and FSM encoding for the FP_Adder host initiator.
package fp_adder_host_if_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int SETUP_W_DEF = 8;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_WAIT = 3'd2,
    ST_GAP  = 3'd3,
    ST_RECV = 3'd4,
    ST_DONE = 3'd5
  } state_e;

endpackage

// File: rtl/fp_adder_host_if_if.sv
// FP_Adder bit-serial bus between host initiator and adder.
// Signal names are from the host's point of view.
interface fp_adder_host_if_if;

  logic adder_serial1_out;
  logic adder_serial2_out;
  logic adder_serial3_out;
  logic adder_serial4_out;
  logic adder_setup_out;
  logic adder_wr_out;
  logic adder_read_out;
  logic adder_input_rdy_in;
  logic adder_output_rdy_in;
  logic adder_serial_in;

  modport master (
    output adder_serial1_out,
    output adder_serial2_out,
    output adder_serial3_out,
    output adder_serial4_out,
    output adder_setup_out,
    output adder_wr_out,
    output adder_read_out,
    input  adder_input_rdy_in,
    input  adder_output_rdy_in,
    input  adder_serial_in
  );

  modport slave (
    input  adder_serial1_out,
    input  adder_serial2_out,
    input  adder_serial3_out,
    input  adder_serial4_out,
    input  adder_setup_out,
    input  adder_wr_out,
    input  adder_read_out,
    output adder_input_rdy_in,
    output adder_output_rdy_in,
    output adder_serial_in
  );

endinterface

// File: rtl/fp_serial_shift.sv
// Right-shifting PISO/SIPO register with parallel load.
// Serial out is the LSB flop; serial in enters at the MSB.
module fp_serial_shift #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] par_in,
  input  logic         ser_in,
  output logic [W-1:0] par_out,
  output logic         ser_out
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  // load has priority over shift
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = par_in;
    end else if (shift) begin
      sr_d = {ser_in, sr_q[W-1:1]};
    end
  end

  // shift register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign par_out = sr_q;
  assign ser_out = sr_q[0];

endmodule

// File: rtl/fp_adder_host_if.sv
// Host initiator for FP_Adder: parallel request in, serial burst
// out, serial result back in, parallel result out.
module fp_adder_host_if
  import fp_adder_host_if_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SETUP_W = SETUP_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               start_in,
  input  logic [WIDTH-1:0]   op_a_in,
  input  logic [WIDTH-1:0]   op_b_in,
  input  logic [WIDTH-1:0]   op_c_in,
  input  logic [WIDTH-1:0]   op_d_in,
  input  logic [SETUP_W-1:0] setup_in,
  output logic               busy_out,
  output logic [WIDTH-1:0]   result_out,
  output logic               result_valid_out,
  output logic               timeout_err_out,
  fp_adder_host_if_if.master adder
);

  localparam int CW = $clog2(WIDTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            wr_q, wr_d;
  logic            rd_q, rd_d;
  logic            busy_q, busy_d;
  logic            vld_q, vld_d;
  logic            tmo_q, tmo_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic load;
  logic tx_shift;
  logic rx_shift;

  logic [WIDTH-1:0]   tx_par [4];
  logic [3:0]         tx_ser;
  logic [SETUP_W-1:0] su_par;
  logic               su_ser;
  logic [WIDTH-1:0]   rx_par;
  logic               rx_ser;
  logic               unused_sig;

  fp_serial_shift #(.W(WIDTH)) u_tx_a (
    .clk(clk_in), .rst_n(rst_n_in), .load(load), .shift(tx_shift),
    .par_in(op_a_in), .ser_in(1'b0),
    .par_out(tx_par[0]), .ser_out(tx_ser[0])
  );

  fp_serial_shift #(.W(WIDTH)) u_tx_b (
    .clk(clk_in), .rst_n(rst_n_in), .load(load), .shift(tx_shift),
    .par_in(op_b_in), .ser_in(1'b0),
    .par_out(tx_par[1]), .ser_out(tx_ser[1])
  );

  fp_serial_shift #(.W(WIDTH)) u_tx_c (
    .clk(clk_in), .rst_n(rst_n_in), .load(load), .shift(tx_shift),
    .par_in(op_c_in), .ser_in(1'b0),
    .par_out(tx_par[2]), .ser_out(tx_ser[2])
  );

  fp_serial_shift #(.W(WIDTH)) u_tx_d (
    .clk(clk_in), .rst_n(rst_n_in), .load(load), .shift(tx_shift),
    .par_in(op_d_in), .ser_in(1'b0),
    .par_out(tx_par[3]), .ser_out(tx_ser[3])
  );

  fp_serial_shift #(.W(SETUP_W)) u_setup (
    .clk(clk_in), .rst_n(rst_n_in), .load(load), .shift(tx_shift),
    .par_in(setup_in), .ser_in(1'b0),
    .par_out(su_par), .ser_out(su_ser)
  );

  fp_serial_shift #(.W(WIDTH)) u_rx (
    .clk(clk_in), .rst_n(rst_n_in), .load(1'b0), .shift(rx_shift),
    .par_in('0), .ser_in(adder.adder_serial_in),
    .par_out(rx_par), .ser_out(rx_ser)
  );

  // Zeros shift in behind the data, so lanes idle low after a burst.
  assign adder.adder_serial4_out = tx_ser[0];
  assign adder.adder_serial3_out = tx_ser[1];
  assign adder.adder_serial2_out = tx_ser[2];
  assign adder.adder_serial1_out = tx_ser[3];
  assign adder.adder_setup_out   = su_ser;
  assign adder.adder_wr_out      = wr_q;
  assign adder.adder_read_out    = rd_q;

  assign busy_out         = busy_q;
  assign result_out       = res_q;
  assign result_valid_out = vld_q;
  assign timeout_err_out  = tmo_q;

  assign unused_sig = ^{tx_par[0], tx_par[1], tx_par[2], tx_par[3],
                        su_par, rx_par[0], rx_ser};

  // next-state, counters and registered strobes
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    busy_d   = busy_q;
    vld_d    = 1'b0;
    tmo_d    = 1'b0;
    res_d    = res_q;
    load     = 1'b0;
    tx_shift = 1'b0;
    rx_shift = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_in && adder.adder_input_rdy_in) begin
          load    = 1'b1;
          cnt_d   = '0;
          wr_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_shift = 1'b1;
        if (cnt_q == CNT_LAST) begin
          wr_d    = 1'b0;
          tmr_d   = '0;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT: begin
        if (adder.adder_output_rdy_in) begin
          rd_d    = 1'b1;
          state_d = ST_GAP;
        end else if (tmr_q == TMR_LAST) begin
          tmo_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_GAP: begin
        cnt_d   = '0;
        state_d = ST_RECV;
      end
      ST_RECV: begin
        rx_shift = 1'b1;
        if (cnt_q == CNT_LAST) begin
          rd_d    = 1'b0;
          busy_d  = 1'b0;
          vld_d   = 1'b1;
          res_d   = {adder.adder_serial_in, rx_par[WIDTH-1:1]};
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // control and result registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
      tmo_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      vld_q   <= vld_d;
      tmo_q   <= tmo_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_fp_adder_host_if.sv
// Bench for fp_adder_host_if with a behavioural FP_Adder far end.
// Expected results come from a real-arithmetic half-precision model.
module tb_fp_adder_host_if;

  localparam int W  = 16;
  localparam int SW = 8;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic [W-1:0]  op_c = '0;
  logic [W-1:0]  op_d = '0;
  logic [SW-1:0] setup = '0;
  logic          busy;
  logic [W-1:0]  res;
  logic          res_vld;
  logic          tmo;

  int n_chk = 0;
  int n_pass = 0;

  logic [15:0] exp_q[$];
  logic [15:0] last_res = '0;
  logic        prev_vld = 1'b0;
  logic        no_rdy = 1'b0;

  fp_adder_host_if_if bus();

  fp_adder_host_if #(.WIDTH(W), .SETUP_W(SW), .TIMEOUT(TO)) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .start_in(start),
    .op_a_in(op_a),
    .op_b_in(op_b),
    .op_c_in(op_c),
    .op_d_in(op_d),
    .setup_in(setup),
    .busy_out(busy),
    .result_out(res),
    .result_valid_out(res_vld),
    .timeout_err_out(tmo),
    .adder(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic real h2r(input logic [15:0] h);
    int  e;
    real m;
    e = int'(h[14:10]);
    if (e == 0) return 0.0;
    m = 1.0 + real'(int'(h[9:0])) / 1024.0;
    while (e > 15) begin m = m * 2.0; e--; end
    while (e < 15) begin m = m / 2.0; e++; end
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    real  m;
    int   e;
    int   fr;
    logic s;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    fr = int'((m - 1.0) * 1024.0);
    return {s, 5'(e + 15), 10'(fr)};
  endfunction

  // Adder semantics: a+b+c+d, or a-b+c-d when setup bit 7 is set.
  function automatic logic [15:0] model(input logic [15:0] a, b, c, d,
                                        input logic [7:0] s);
    real r;
    if (s[7]) r = h2r(a) - h2r(b) + h2r(c) - h2r(d);
    else      r = h2r(a) + h2r(b) + h2r(c) + h2r(d);
    return r2h(r);
  endfunction

  function automatic logic [15:0] rand_half();
    int k;
    k = int'($urandom_range(0, 256));
    return r2h(real'(k - 128) / 4.0);
  endfunction

  // Far end: collects operand bursts, answers after a short delay.
  int          wr_n = 0;
  int          rd_n = 0;
  int          wait_n = 0;
  logic        pend = 1'b0;
  logic [15:0] fa, fb, fc, fd, fs;
  logic [15:0] f_res = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      wr_n = 0;
      rd_n = 0;
      pend = 1'b0;
      bus.adder_output_rdy_in = 1'b0;
      bus.adder_serial_in = 1'b0;
    end else begin
      if (bus.adder_wr_out) begin
        if (wr_n < 16) begin
          fa[wr_n] = bus.adder_serial4_out;
          fb[wr_n] = bus.adder_serial3_out;
          fc[wr_n] = bus.adder_serial2_out;
          fd[wr_n] = bus.adder_serial1_out;
          fs[wr_n] = bus.adder_setup_out;
        end
        wr_n++;
      end else if (wr_n != 0) begin
        chk("wr_len", 32'(wr_n), 32'd16);
        chk("setup_tail", 32'(fs[15:8]), 32'd0);
        f_res = model(fa, fb, fc, fd, fs[7:0]);
        pend = !no_rdy;
        wait_n = int'($urandom_range(1, 4));
        wr_n = 0;
      end
      if (pend && !bus.adder_read_out) begin
        if (wait_n > 0) wait_n--;
        else bus.adder_output_rdy_in = 1'b1;
      end
      if (bus.adder_read_out) begin
        pend = 1'b0;
        bus.adder_output_rdy_in = 1'b0;
        rd_n++;
        if (rd_n >= 2 && rd_n <= 17) bus.adder_serial_in = f_res[rd_n-2];
        else bus.adder_serial_in = 1'b0;
      end else begin
        rd_n = 0;
        bus.adder_serial_in = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every result pulse.
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst_n && res_vld) begin
      chk("valid_pulse", 32'(prev_vld), 32'd0);
      chk("pending_request", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("result", 32'(res), 32'(e));
        chk("busy_at_done", 32'(busy), 32'd0);
        last_res = e;
      end
    end
    prev_vld = res_vld;
  end

  function automatic logic [31:0] all_outs();
    return 32'({busy, res_vld, tmo, res,
                bus.adder_serial1_out, bus.adder_serial2_out,
                bus.adder_serial3_out, bus.adder_serial4_out,
                bus.adder_setup_out, bus.adder_wr_out,
                bus.adder_read_out});
  endfunction

  task automatic issue(input logic [15:0] a, b, c, d,
                       input logic [7:0] s, input bit push);
    int n;
    @(negedge clk);
    op_a = a; op_b = b; op_c = c; op_d = d; setup = s;
    start = 1'b1;
    n = 0;
    while (!busy && n < 200) begin @(negedge clk); n++; end
    chk("accept", 32'(busy), 32'd1);
    if (busy && push) exp_q.push_back(model(a, b, c, d, s));
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 400) begin @(negedge clk); n++; end
    chk("complete", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    int m;
    logic rd_any;
    logic any_busy;
    logic [15:0] a, b, c, d;
    logic [7:0] s;

    bus.adder_input_rdy_in = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    issue(16'h3C00, 16'h3C00, 16'h0000, 16'h0000, 8'h1E, 1'b1);
    wait_idle();
    issue(16'h4880, 16'h3C00, 16'h3800, 16'h3400, 8'h1E, 1'b1);
    wait_idle();
    issue(16'h3C00, 16'h4000, 16'h4500, 16'h4B00, 8'hBE, 1'b1);
    wait_idle();
    chk("directed_c900", 32'(last_res), 32'h0000C900);

    // back-to-back with start held high
    @(negedge clk);
    op_a = 16'h3C00; op_b = 16'hBC00; op_c = '0; op_d = '0;
    setup = 8'h1E;
    start = 1'b1;
    n = 0;
    while (!busy && n < 200) begin @(negedge clk); n++; end
    chk("b2b_accept1", 32'(busy), 32'd1);
    exp_q.push_back(model(16'h3C00, 16'hBC00, 16'h0, 16'h0, 8'h1E));
    op_a = 16'h3C00; op_b = 16'hBC00; setup = 8'h9E;
    n = 0;
    while (!res_vld && n < 200) begin @(negedge clk); n++; end
    m = 0;
    do begin @(negedge clk); m++; end while (!busy && m < 10);
    chk("b2b_reaccept_gap", 32'(m), 32'd2);
    exp_q.push_back(model(16'h3C00, 16'hBC00, 16'h0, 16'h0, 8'h9E));
    start = 1'b0;
    wait_idle();
    chk("b2b_last", 32'(last_res), 32'h00004000);

    // far end never answers
    no_rdy = 1'b1;
    issue(16'h4000, 16'h4000, 16'h0, 16'h0, 8'h1E, 1'b0);
    n = 0;
    while (bus.adder_wr_out && n < 100) begin @(negedge clk); n++; end
    m = 0;
    rd_any = bus.adder_read_out;
    while (!tmo && m < 200) begin
      @(negedge clk);
      m++;
      rd_any = rd_any | bus.adder_read_out;
    end
    chk("timeout_cycles", 32'(m), 32'(TO));
    chk("timeout_busy", 32'(busy), 32'd0);
    chk("timeout_result_held", 32'(res), 32'(last_res));
    chk("timeout_no_read", 32'(rd_any), 32'd0);
    @(negedge clk);
    chk("timeout_pulse_width", 32'(tmo), 32'd0);
    no_rdy = 1'b0;
    repeat (2) @(negedge clk);

    // reset in RECV cycle 5
    issue(16'h4000, 16'h3C00, 16'h3C00, 16'h0, 8'h1E, 1'b1);
    n = 0;
    while (!bus.adder_read_out && n < 200) begin @(negedge clk); n++; end
    repeat (6) @(negedge clk);
    chk("read_before_reset", 32'(bus.adder_read_out), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", all_outs(), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    issue(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 8'h1E, 1'b1);
    wait_idle();
    chk("after_reset_4400", 32'(last_res), 32'h00004400);

    // randomized traffic
    for (int i = 0; i < 25; i++) begin
      a = rand_half(); b = rand_half();
      c = rand_half(); d = rand_half();
      s = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        bus.adder_input_rdy_in = 1'b0;
        start = 1'b1;
        any_busy = 1'b0;
        repeat (3) begin
          @(negedge clk);
          any_busy = any_busy | busy;
        end
        chk("no_accept_not_rdy", 32'(any_busy), 32'd0);
        start = 1'b0;
        bus.adder_input_rdy_in = 1'b1;
      end
      issue(a, b, c, d, s, 1'b1);
      wait_idle();
    end

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
